// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, halt/redirect FSM and IF/ID buffer.
// One-edge fetch latency; in_hz freezes PC, buffer and state in place.
module if_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        CLOCK,
   input  logic        in_rst,
   input  logic        in_hz,
   input  logic        in_pc_src,
   input  logic [15:0] in_br_target,
   input  logic [15:0] in_imem_data,
   output logic [15:0] out_imem_addr,
   output logic [15:0] out_buf,
   output logic [15:0] out_buf_pc,
   output logic        out_buf_valid,
   output logic        out_halt
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] buf_q, buf_d;
   logic [15:0] buf_pc_q, buf_pc_d;
   logic        buf_valid_q, buf_valid_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_d       = buf_q;
      buf_pc_d    = buf_pc_q;
      buf_valid_d = buf_valid_q;
      if (in_pc_src) begin
         // Redirect beats stall and also releases a halted fetch.
         pc_d        = in_br_target;
         buf_d       = 16'h0000;
         buf_pc_d    = 16'h0000;
         buf_valid_d = 1'b0;
         state_d     = RUN;
      end else if (in_hz) begin
         state_d = state_q;
      end else if (state_q == RUN) begin
         buf_d       = in_imem_data;
         buf_pc_d    = pc_q;
         buf_valid_d = 1'b1;
         if (in_imem_data[15:12] == 4'b1111) begin
            state_d = HALTED;
         end else begin
            pc_d = pc_q + 16'd1;
         end
      end else begin
         buf_d       = 16'h0000;
         buf_pc_d    = 16'h0000;
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (in_rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         buf_q       <= 16'h0000;
         buf_pc_q    <= 16'h0000;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_q       <= buf_d;
         buf_pc_q    <= buf_pc_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   assign out_imem_addr = pc_q;
   assign out_buf       = buf_q;
   assign out_buf_pc    = buf_pc_q;
   assign out_buf_valid = buf_valid_q;
   assign out_halt      = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against both DUT instances.
module tb_if_stage;

   typedef struct {
      string       name;
      logic [15:0] addr;
      logic [15:0] bf;
      logic [15:0] bpc;
      logic        v;
      logic        h;
   } exp_t;

   logic        CLOCK = 1'b0;
   logic        rst = 1'b0, hz = 1'b0, pc_src = 1'b0;
   logic [15:0] br_target = 16'h0000;
   logic [15:0] imem_data, imem_addr, obuf, obuf_pc;
   logic        obuf_valid, ohalt;

   logic        rst2 = 1'b0;
   logic        hz2 = 1'b0, pc_src2 = 1'b0;
   logic [15:0] br_target2 = 16'h0000;
   logic [15:0] imem_data2, imem_addr2, obuf2, obuf_pc2;
   logic        obuf_valid2, ohalt2;

   exp_t q1[$];
   exp_t q2[$];
   int checks = 0;
   int failures = 0;

   always #5 CLOCK = ~CLOCK;

   function automatic logic [15:0] mem(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h0120;
         16'h0001: return 16'h0121;
         16'h0002: return 16'h0122;
         16'h0003: return 16'h0123;
         16'h0004: return 16'h0124;
         16'h0005: return 16'hF000;
         16'h0010: return 16'h0B10;
         16'h0040: return 16'h0A40;
         16'h0041: return 16'h0A41;
         default:  return 16'h0000;
      endcase
   endfunction

   assign imem_data  = mem(imem_addr);
   assign imem_data2 = 16'h0777;

   if_stage #(.RESET_PC(16'h0000)) dut (
      .CLOCK(CLOCK), .in_rst(rst), .in_hz(hz), .in_pc_src(pc_src),
      .in_br_target(br_target), .in_imem_data(imem_data),
      .out_imem_addr(imem_addr), .out_buf(obuf), .out_buf_pc(obuf_pc),
      .out_buf_valid(obuf_valid), .out_halt(ohalt)
   );

   if_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
      .CLOCK(CLOCK), .in_rst(rst2), .in_hz(hz2), .in_pc_src(pc_src2),
      .in_br_target(br_target2), .in_imem_data(imem_data2),
      .out_imem_addr(imem_addr2), .out_buf(obuf2), .out_buf_pc(obuf_pc2),
      .out_buf_valid(obuf_valid2), .out_halt(ohalt2)
   );

   task automatic step(input string nm, input logic r, input logic ps, input logic h_in,
                       input logic [15:0] tgt, input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] ep, input logic ev, input logic eh);
      exp_t e;
      rst = r; pc_src = ps; hz = h_in; br_target = tgt;
      @(posedge CLOCK);
      #1;
      e.name = nm; e.addr = ea; e.bf = eb; e.bpc = ep; e.v = ev; e.h = eh;
      q1.push_back(e);
   endtask

   task automatic push2(input string nm, input logic [15:0] ea, input logic [15:0] eb,
                        input logic [15:0] ep, input logic ev);
      exp_t e;
      e.name = nm; e.addr = ea; e.bf = eb; e.bpc = ep; e.v = ev; e.h = 1'b0;
      q2.push_back(e);
   endtask

   always @(negedge CLOCK) begin
      exp_t e;
      if (q1.size() != 0) begin
         e = q1.pop_front();
         checks++;
         if ({imem_addr, obuf, obuf_pc, obuf_valid, ohalt} !== {e.addr, e.bf, e.bpc, e.v, e.h}) begin
            failures++;
            $display("FAIL %s: got addr=%h buf=%h pc=%h v=%b halt=%b, want addr=%h buf=%h pc=%h v=%b halt=%b",
                     e.name, imem_addr, obuf, obuf_pc, obuf_valid, ohalt, e.addr, e.bf, e.bpc, e.v, e.h);
         end
      end
      if (q2.size() != 0) begin
         e = q2.pop_front();
         checks++;
         if ({imem_addr2, obuf2, obuf_pc2, obuf_valid2, ohalt2} !== {e.addr, e.bf, e.bpc, e.v, e.h}) begin
            failures++;
            $display("FAIL %s: got addr=%h buf=%h pc=%h v=%b halt=%b, want addr=%h buf=%h pc=%h v=%b halt=%b",
                     e.name, imem_addr2, obuf2, obuf_pc2, obuf_valid2, ohalt2, e.addr, e.bf, e.bpc, e.v, e.h);
         end
      end
   end

   initial begin
      rst2 = 1'b1;
      step("reset1",   1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      step("reset2",   1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      push2("wrap_reset", 16'hFFFF, 16'h0000, 16'h0000, 0);
      rst2 = 1'b0;
      step("seq1",     0, 0, 0, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      push2("wrap_fetch", 16'h0000, 16'h0777, 16'hFFFF, 1);
      step("stall1",   0, 0, 1, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      step("stall2",   0, 0, 1, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      step("release",  0, 0, 0, 16'h0000, 16'h0002, 16'h0121, 16'h0001, 1, 0);
      step("redir_hz", 0, 1, 1, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 0, 0);
      step("after_rd", 0, 0, 0, 16'h0000, 16'h0041, 16'h0A40, 16'h0040, 1, 0);
      step("redir3",   0, 1, 0, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 0, 0);
      step("fetch3",   0, 0, 0, 16'h0000, 16'h0004, 16'h0123, 16'h0003, 1, 0);
      step("fetch4",   0, 0, 0, 16'h0000, 16'h0005, 16'h0124, 16'h0004, 1, 0);
      step("halt",     0, 0, 0, 16'h0000, 16'h0005, 16'hF000, 16'h0005, 1, 1);
      step("halted1",  0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 1);
      step("halted2",  0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 1);
      step("halted3",  0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 1);
      step("halt_hz",  0, 0, 1, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 1);
      step("unhalt",   0, 1, 0, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 0, 0);
      step("fetch10",  0, 0, 0, 16'h0000, 16'h0011, 16'h0B10, 16'h0010, 1, 0);
      step("redir5",   0, 1, 0, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 0, 0);
      step("halt_b",   0, 0, 0, 16'h0000, 16'h0005, 16'hF000, 16'h0005, 1, 1);
      step("rst_all",  1, 1, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      step("post_rst", 0, 0, 0, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      step("stall_r",  0, 0, 1, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      step("rst_stl",  1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      step("fin",      0, 0, 0, 16'h0000, 16'h0001, 16'h0120, 16'h0000, 1, 0);
      repeat (3) @(negedge CLOCK);
      #1;
      checks++;
      if (q1.size() + q2.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending, want 0", q1.size() + q2.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
